rho_rotate: RTL
===============

# rho_rotate

Keccak rho stage of the encoder pipeline, directly downstream of the column-parity (theta) stage.
- Accepts the theta output as a stream of 25-bit slices, one slice per z, z = 0 first.
- Buffers the full 5x5xLANE_W state.
- Re-emits it slice by slice with every lane rotated by its fixed rho offset, for the pi/chi stages.

## Interface
Parameters:
- LANE_W, 64, lane length and slice count per frame; power of two, 8..64; ZW = $clog2(LANE_W).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low. Asserting (0) immediately forces the reset state.
- in_valid  input  1  in_slice holds a valid slice.
- in_ready  output  1  block can accept a slice this cycle.
- in_slice  input  25  slice z. Bit i = 5*y + x holds lane (x,y) bit z.
- out_valid  output  1  out_slice/out_z are valid.
- out_ready  input  1  downstream accepts the slice this cycle.
- out_slice  output  25  rotated slice, same bit ordering as in_slice.
- out_z  output  ZW  z index of out_slice.
- finish  output  1  one-cycle pulse: frame fully emitted.

## Operation
Handshakes:
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.

LOAD state:
- Input transfers write buffer slice wz, then wz increments.
- in_ready = 1, out_valid = 0.
- When the transfer with wz = LANE_W-1 occurs: wz wraps to 0 and the FSM goes to EMIT.

EMIT state:
- out_valid = 1 and out_z = rz.
- out_slice bit (5y+x) = buffered lane(x,y) bit ((rz - r[x][y]) mod LANE_W), with modular ZW-bit subtraction. This is a left rotation by r.
- Each output transfer increments rz.
- When the transfer with rz = LANE_W-1 occurs: rz wraps to 0, finish pulses, and the FSM returns to LOAD.
- out_slice and out_z hold stable while out_valid && !out_ready.

Rho offsets r[x][y], listed per y as x = 0..4, taken mod LANE_W:
- y0: 0, 1, 62, 28, 27
- y1: 36, 44, 6, 55, 20
- y2: 3, 10, 43, 25, 39
- y3: 41, 45, 15, 21, 8
- y4: 18, 2, 61, 56, 14

Reset state:
- FSM = LOAD, wz = rz = 0.
- in_ready = 1, out_valid = 0, finish = 0, out_z = 0.
- out_slice is don't-care while out_valid = 0.
- Buffer contents are not reset.
- Reset mid-frame discards the partial or pending frame; no finish pulse is produced.

## Timing
- Latency: out_valid rises in the cycle after the last input transfer, showing slice 0 combinationally from the buffer.
- Throughput with out_ready held at 1: one slice per cycle.
- A frame takes 2*LANE_W cycles without overlap.
- finish is registered: it is high for exactly the cycle after the last output transfer.
- While in EMIT without the macro, in_ready = 0. Input is ignored and never dropped silently, since no transfer occurs.
- No combinational path from out_ready to in_ready.

## Configuration
RHO_PINGPONG_EN:
- Defined:
  - Two buffer banks. Loading frame N+1 into the free bank overlaps emission of frame N.
  - in_ready = 0 only when both banks hold unemitted frames.
  - When a frame completes loading while the other bank is emitting, it queues. Its emission starts the cycle after finish of the previous frame, so out_valid stays 1 across the boundary and out_z wraps 63 -> 0.
  - A simultaneous last-input transfer and last-output transfer in one cycle is legal: both complete and banks swap.
  - Sustained throughput is 1 slice/cycle.
- Undefined: single bank, behaviour as in Operation.

## Test plan
- Single bit, lane (1,0): slice z=0 = 25'h0000002, all other slices 0, out_ready=1 -> only out_z=1 has out_slice=25'h0000002. out_valid is first high the cycle after the 64th input; finish is high the cycle after out_z=63.
- Lane (0,0), offset 0: slice z=5 = 25'h0000001 -> out_z=5 has bit 0 set, all other output slices 0.
- Wrap-around, lane (2,0), r=62: slice z=3 = 25'h0000004 -> out_z=1 (65 mod 64) has bit 2 set.
- Backpressure: out_ready toggling 1,0,0,1 -> out_slice/out_z hold while stalled; 64 transfers total; finish exactly once.
- Reset pulse after 30 loaded slices -> in_ready=1, out_valid=0 immediately. A new full frame of 64 slices then emits correctly, with no stale data from the aborted frame.
- RHO_PINGPONG_EN: two back-to-back frames, out_ready=1 -> in_ready stays 1 throughout. 128 consecutive out_valid cycles. finish pulses at cycles 64 and 128 after the first out_valid.

Source files
------------

// File: rtl/rho_rotate.sv
// Keccak rho stage: buffers a 5x5xLANE_W state slice-by-slice and re-emits it with every lane rotated left by its rho offset.
// Optional macro RHO_PINGPONG_EN adds a second bank so loading the next frame overlaps emission of the current one.
module rho_rotate #(
  parameter  int LANE_W = 64,
  localparam int ZW     = $clog2(LANE_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [24:0]   in_slice,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [24:0]   out_slice,
  output logic [ZW-1:0] out_z,
  output logic          finish
);

  localparam int            NL     = 25;
  localparam logic [ZW-1:0] Z_LAST = ZW'(LANE_W - 1);

  // Offsets indexed by lane number 5*y + x.
  localparam int RHO_OFS [NL] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_in_last;
  logic          w_out_last;
  logic [ZW-1:0] r_wz;
  logic [ZW-1:0] r_rz;
  logic          r_finish;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_in_last  = w_in_xfer && (r_wz == Z_LAST);
  assign w_out_last = w_out_xfer && (r_rz == Z_LAST);

  assign out_z  = r_rz;
  assign finish = r_finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wz     <= '0;
      r_rz     <= '0;
      r_finish <= 1'b0;
    end else begin
      if (w_in_xfer)  r_wz <= r_wz + ZW'(1);
      if (w_out_xfer) r_rz <= r_rz + ZW'(1);
      r_finish <= w_out_last;
    end
  end

`ifdef RHO_PINGPONG_EN
  // r_wb: bank being loaded, r_eb: bank being emitted; r_full marks banks holding an unemitted frame.
  logic              r_wb;
  logic              r_eb;
  logic [1:0]        r_full;
  logic [1:0]        w_full_next;
  logic [LANE_W-1:0] r_buf [2][NL];

  always_comb begin
    w_full_next = r_full;
    if (w_in_last)  w_full_next[r_wb] = 1'b1;
    if (w_out_last) w_full_next[r_eb] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb   <= 1'b0;
      r_eb   <= 1'b0;
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_next;
      if (w_in_last)  r_wb <= ~r_wb;
      if (w_out_last) r_eb <= ~r_eb;
    end
  end

  assign in_ready  = !r_full[r_wb];
  assign out_valid = r_full[r_eb];

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      for (int i = 0; i < NL; i++) begin
        r_buf[r_wb][i][r_wz] <= in_slice[i];
      end
    end
  end
`else
  typedef enum logic {S_LOAD, S_EMIT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [LANE_W-1:0] r_buf [NL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  if (w_in_last)  w_state_next = S_EMIT;
      S_EMIT:  if (w_out_last) w_state_next = S_LOAD;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_LOAD);
    out_valid = (r_state == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      for (int i = 0; i < NL; i++) begin
        r_buf[i][r_wz] <= in_slice[i];
      end
    end
  end
`endif

  // Each lane reads its own bit position, so the buffer is per-lane registers rather than a slice-wide RAM.
  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      localparam logic [ZW-1:0] OFS = ZW'(RHO_OFS[gi] % LANE_W);
      wire [ZW-1:0] w_idx = r_rz - OFS;
`ifdef RHO_PINGPONG_EN
      assign out_slice[gi] = r_buf[r_eb][gi][w_idx];
`else
      assign out_slice[gi] = r_buf[gi][w_idx];
`endif
    end
  endgenerate

endmodule
